gate_issue_ctrl: RTL and testbench
==================================

GATE_ISSUE_CTRL -- requirements
Module: gate_issue_ctrl

Interface
REQ-001 SHALL have parameters: S, 20, wire-address width; W_OUT, 5, outstanding-gate counter width (MAX_OUT = 2**W_OUT-1).
REQ-002 SHALL use reset rst, asynchronous, active-high; clock clk.
REQ-003 SHALL have ports:
  clk  in  1  clock;
  rst  in  1  async active-high reset;
  start  in  1  begin-circuit pulse;
  n_gates  in  32  gate count, sampled on start;
  in_valid/in_ready  in/out  1  descriptor handshake;
  in_addr_a, in_addr_b, in_addr_o  in  S  descriptor input/output wires;
  load_en, load_addr  in  1/S  circuit-input wire label loaded;
  iss_valid/iss_ready  out/in  1  issue handshake;
  iss_addr_a, iss_addr_b, iss_addr_o  out  S  issued descriptor;
  cmp_valid, cmp_addr  in  1/S  gate completed, output wire label written;
  ram_clr  out  1;
  ram_wr_en_0, ram_wr_en_1  out  1;
  ram_wr_addr_0, ram_wr_addr_1  out  S;
  ram_wr_data_0, ram_wr_data_1  out  1;
  ram_rd_addr_0, ram_rd_addr_1  out  S;
  ram_rd_data_0, ram_rd_data_1  in  1  (single-bit ready-flag RAM, combinational read);
  busy, done  out  1;
  stall_cnt  out  32.

Function
REQ-004 SHALL implement FSM IDLE, CLR, RUN, DRAIN, FIN; start honoured only in IDLE.
REQ-005 IDLE+start -> CLR: latch n_gates, zero counters; CLR asserts ram_clr one cycle.
REQ-006 CLR -> RUN if latched n_gates != 0, else CLR -> FIN.
REQ-007 ram_rd_addr_0/1 SHALL equal in_addr_a/in_addr_b combinationally in every state.
REQ-008 Operand ready = ram_rd_data_x OR (cmp_valid AND cmp_addr == in_addr_x) OR (load_en AND load_addr == in_addr_x) (same-cycle bypass).
REQ-009 in_ready SHALL be 1 only in RUN with both operands ready, issued < n_gates, outstanding + issue-slot occupancy < MAX_OUT, and (!iss_valid OR iss_ready).
REQ-010 Descriptor accepted in cycle t SHALL appear on iss_* with iss_valid at t+1; iss_* SHALL hold stable while iss_valid & !iss_ready.
REQ-011 Port 0 writes: ram_wr_en_0 = cmp_valid, ram_wr_addr_0 = cmp_addr, data 1, in RUN/DRAIN only.
REQ-012 Port 1 writes: ram_wr_en_1 = load_en, ram_wr_addr_1 = load_addr, data 1, in RUN only; same-address collision with port 0 is harmless (both write 1).
REQ-013 Outstanding SHALL +1 on iss_valid&iss_ready, -1 on cmp_valid, unchanged when both; decrement saturates at 0.
REQ-014 RUN -> DRAIN when issued count reaches n_gates; DRAIN -> FIN when outstanding == 0 and !iss_valid.
REQ-015 FIN asserts done for exactly one cycle, then IDLE; busy = 1 in CLR, RUN, DRAIN.
REQ-016 stall_cnt SHALL increment each RUN cycle with in_valid & !in_ready, wrap at 2**32, clear on start.

Reset
REQ-017 rst SHALL force IDLE; all outputs, counters and issue register to 0, independent of clk.
REQ-018 rst mid-circuit SHALL discard in-flight descriptors; no ram_clr issued by reset.

Structure
REQ-019 Shared package SHALL hold the FSM state enum and the gate descriptor struct {a, b, o} parameterised by S.
REQ-020 Single module; no sub-module; ready-flag RAM is instantiated alongside, not inside.

Verification
REQ-021 n_gates=0, start -> ram_clr at cycle 1, done pulse at cycle 2, no issue.
REQ-022 Load wires 0,1; descriptor (0,1,2) -> iss_valid next cycle with addrs 0,1,2; cmp_addr=2 -> outstanding 0, done.
REQ-023 Descriptor (2,3,4) before wire 2 ready -> in_ready=0, stall_cnt increments per cycle; cmp_addr=2 and load 3 same cycle -> accepted that cycle (bypass).
REQ-024 W_OUT=2, no completions -> at most 3 issues, then in_ready=0 until cmp_valid.
REQ-025 iss_ready held 0 for 5 cycles -> iss_* stable, no further acceptance; release -> resumes.
REQ-026 rst asserted in RUN with 2 outstanding -> next cycle IDLE, all outputs 0; new start works normally.

Source files
------------

// File: rtl/gate_issue_ctrl_pkg.sv
// Shared types for the gate issue controller: FSM states, gate descriptor
// layout and the same-cycle address-match helper used by the operand bypass.
package gate_issue_ctrl_pkg;

  localparam int unsigned GIC_S = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } gic_state_e;

  typedef struct packed {
    logic [GIC_S-1:0] a;
    logic [GIC_S-1:0] b;
    logic [GIC_S-1:0] o;
  } gate_desc_t;

  function automatic logic addr_hit(input logic vld, input logic [GIC_S-1:0] x,
                                    input logic [GIC_S-1:0] y);
    return vld && (x == y);
  endfunction

endpackage

// File: rtl/gate_issue_ctrl.sv
// Gate issue controller: admits gate descriptors once both input wire labels
// are ready, bounds outstanding gates, and sequences clear/run/drain per circuit.
module gate_issue_ctrl
  import gate_issue_ctrl_pkg::*;
#(
  parameter int unsigned S     = GIC_S,
  parameter int unsigned W_OUT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  n_gates,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [S-1:0] in_addr_a,
  input  logic [S-1:0] in_addr_b,
  input  logic [S-1:0] in_addr_o,
  input  logic         load_en,
  input  logic [S-1:0] load_addr,
  output logic         iss_valid,
  input  logic         iss_ready,
  output logic [S-1:0] iss_addr_a,
  output logic [S-1:0] iss_addr_b,
  output logic [S-1:0] iss_addr_o,
  input  logic         cmp_valid,
  input  logic [S-1:0] cmp_addr,
  output logic         ram_clr,
  output logic         ram_wr_en_0,
  output logic         ram_wr_en_1,
  output logic [S-1:0] ram_wr_addr_0,
  output logic [S-1:0] ram_wr_addr_1,
  output logic         ram_wr_data_0,
  output logic         ram_wr_data_1,
  output logic [S-1:0] ram_rd_addr_0,
  output logic [S-1:0] ram_rd_addr_1,
  input  logic         ram_rd_data_0,
  input  logic         ram_rd_data_1,
  output logic         busy,
  output logic         done,
  output logic [31:0]  stall_cnt
);

  localparam logic [W_OUT:0] MAX_OUT = {1'b0, {W_OUT{1'b1}}};

  gic_state_e       state_q, state_d;
  logic [31:0]      n_gates_q, n_gates_d;
  logic [31:0]      issued_q, issued_d;
  logic [W_OUT-1:0] out_q, out_d;
  logic [31:0]      stall_q, stall_d;
  gate_desc_t       iss_q, iss_d;
  logic             iss_valid_q, iss_valid_d;

  logic             rdy_a, rdy_b, accept, iss_fire, cmp_cnt;
  logic [W_OUT:0]   out_sum;

  // State and datapath registers; reset drops any in-flight descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      n_gates_q   <= 32'd0;
      issued_q    <= 32'd0;
      out_q       <= '0;
      stall_q     <= 32'd0;
      iss_q       <= '0;
      iss_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_gates_q   <= n_gates_d;
      issued_q    <= issued_d;
      out_q       <= out_d;
      stall_q     <= stall_d;
      iss_q       <= iss_d;
      iss_valid_q <= iss_valid_d;
    end
  end

  // Admission, issue-slot, counters and next-state logic.
  always_comb begin
    state_d     = state_q;
    n_gates_d   = n_gates_q;
    issued_d    = issued_q;
    out_d       = out_q;
    stall_d     = stall_q;
    iss_d       = iss_q;
    iss_valid_d = iss_valid_q;

    // A label written this very cycle counts as ready (bypass around the RAM).
    rdy_a = ram_rd_data_0 | addr_hit(cmp_valid, cmp_addr, in_addr_a)
          | addr_hit(load_en, load_addr, in_addr_a);
    rdy_b = ram_rd_data_1 | addr_hit(cmp_valid, cmp_addr, in_addr_b)
          | addr_hit(load_en, load_addr, in_addr_b);

    out_sum  = {1'b0, out_q} + {{W_OUT{1'b0}}, iss_valid_q};
    in_ready = (state_q == ST_RUN) && rdy_a && rdy_b && (issued_q < n_gates_q)
             && (out_sum < MAX_OUT) && (!iss_valid_q || iss_ready);
    accept   = in_valid && in_ready;
    iss_fire = iss_valid_q && iss_ready;
    cmp_cnt  = cmp_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));

    if (accept) begin
      iss_d       = '{a: in_addr_a, b: in_addr_b, o: in_addr_o};
      iss_valid_d = 1'b1;
    end else if (iss_fire) begin
      iss_valid_d = 1'b0;
    end else begin
      iss_valid_d = iss_valid_q;
    end

    issued_d = issued_q + {31'd0, accept};

    case ({iss_fire, cmp_cnt})
      2'b10:   out_d = out_q + {{(W_OUT-1){1'b0}}, 1'b1};
      2'b01:   out_d = (out_q == '0) ? out_q : out_q - {{(W_OUT-1){1'b0}}, 1'b1};
      default: out_d = out_q;
    endcase

    if ((state_q == ST_RUN) && in_valid && !in_ready) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CLR;
          n_gates_d   = n_gates;
          issued_d    = 32'd0;
          out_d       = '0;
          stall_d     = 32'd0;
          iss_valid_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR:   state_d = (n_gates_q != 32'd0) ? ST_RUN : ST_FIN;
      ST_RUN:   state_d = (issued_d == n_gates_q) ? ST_DRAIN : ST_RUN;
      ST_DRAIN: state_d = ((out_q == '0) && !iss_valid_q) ? ST_FIN : ST_DRAIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign iss_valid  = iss_valid_q;
  assign iss_addr_a = iss_q.a;
  assign iss_addr_b = iss_q.b;
  assign iss_addr_o = iss_q.o;

  assign ram_rd_addr_0 = in_addr_a;
  assign ram_rd_addr_1 = in_addr_b;

  assign ram_clr       = (state_q == ST_CLR);
  assign ram_wr_en_0   = cmp_valid && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
  assign ram_wr_addr_0 = cmp_addr;
  assign ram_wr_data_0 = 1'b1;
  assign ram_wr_en_1   = load_en && (state_q == ST_RUN);
  assign ram_wr_addr_1 = load_addr;
  assign ram_wr_data_1 = 1'b1;

  assign busy      = (state_q == ST_CLR) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_FIN);
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_gate_issue_ctrl.sv
// Directed bench for gate_issue_ctrl with a behavioural single-bit ready-flag RAM
// (W_OUT=2 so the outstanding limit is 3).
module tb_gate_issue_ctrl;
  localparam int S = 20;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, load_en, iss_ready, cmp_valid;
  logic [31:0]  n_gates;
  logic [S-1:0] in_addr_a, in_addr_b, in_addr_o, load_addr, cmp_addr;
  logic         in_ready, iss_valid, ram_clr, ram_wr_en_0, ram_wr_en_1;
  logic [S-1:0] iss_addr_a, iss_addr_b, iss_addr_o;
  logic [S-1:0] ram_wr_addr_0, ram_wr_addr_1, ram_rd_addr_0, ram_rd_addr_1;
  logic         ram_wr_data_0, ram_wr_data_1, ram_rd_data_0, ram_rd_data_1;
  logic         busy, done;
  logic [31:0]  stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  logic flags [0:255];

  always #5 clk = ~clk;

  gate_issue_ctrl #(.S(S), .W_OUT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .n_gates(n_gates),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr_a(in_addr_a), .in_addr_b(in_addr_b), .in_addr_o(in_addr_o),
    .load_en(load_en), .load_addr(load_addr),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_addr_a(iss_addr_a), .iss_addr_b(iss_addr_b), .iss_addr_o(iss_addr_o),
    .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .ram_clr(ram_clr),
    .ram_wr_en_0(ram_wr_en_0), .ram_wr_en_1(ram_wr_en_1),
    .ram_wr_addr_0(ram_wr_addr_0), .ram_wr_addr_1(ram_wr_addr_1),
    .ram_wr_data_0(ram_wr_data_0), .ram_wr_data_1(ram_wr_data_1),
    .ram_rd_addr_0(ram_rd_addr_0), .ram_rd_addr_1(ram_rd_addr_1),
    .ram_rd_data_0(ram_rd_data_0), .ram_rd_data_1(ram_rd_data_1),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  // Ready-flag RAM model
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) flags[i] <= 1'b0;
    end else begin
      if (ram_wr_en_0) flags[ram_wr_addr_0[7:0]] <= ram_wr_data_0;
      if (ram_wr_en_1) flags[ram_wr_addr_1[7:0]] <= ram_wr_data_1;
    end
  end
  assign ram_rd_data_0 = flags[ram_rd_addr_0[7:0]];
  assign ram_rd_data_1 = flags[ram_rd_addr_1[7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic desc(input logic v, input int a, input int b, input int o);
    in_valid  = v;
    in_addr_a = S'(a);
    in_addr_b = S'(b);
    in_addr_o = S'(o);
  endtask

  task automatic do_load(input int addr);
    load_en = 1'b1; load_addr = S'(addr);
    tick();
    load_en = 1'b0;
  endtask

  task automatic begin_circuit(input int n);
    start = 1'b1; n_gates = n;
    tick();
    start = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; n_gates = 32'd0; in_valid = 1'b0;
    in_addr_a = '0; in_addr_b = '0; in_addr_o = '0;
    load_en = 1'b0; load_addr = '0; iss_ready = 1'b0; cmp_valid = 1'b0; cmp_addr = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_clr", {31'd0, ram_clr}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // empty circuit: clear then done, never issue
    begin_circuit(0);
    chk("n0_clr", {31'd0, ram_clr}, 32'd1);
    chk("n0_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("n0_done", {31'd0, done}, 32'd1);
    chk("n0_clr_off", {31'd0, ram_clr}, 32'd0);
    chk("n0_no_iss", {31'd0, iss_valid}, 32'd0);
    tick();
    chk("n0_done_off", {31'd0, done}, 32'd0);

    // single gate with loaded inputs
    begin_circuit(1);
    tick();
    load_en = 1'b1; load_addr = S'(0);
    #1;
    chk("ld_wr_en1", {31'd0, ram_wr_en_1}, 32'd1);
    tick();
    do_load(1);
    iss_ready = 1'b1;
    desc(1'b1, 0, 1, 2);
    #1;
    chk("g1_rd_addr0", {12'd0, ram_rd_addr_0}, 32'd0);
    chk("g1_rd_addr1", {12'd0, ram_rd_addr_1}, 32'd1);
    chk("g1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    desc(1'b0, 0, 1, 2);
    #1;
    chk("g1_iss_valid", {31'd0, iss_valid}, 32'd1);
    chk("g1_iss_a", {12'd0, iss_addr_a}, 32'd0);
    chk("g1_iss_b", {12'd0, iss_addr_b}, 32'd1);
    chk("g1_iss_o", {12'd0, iss_addr_o}, 32'd2);
    tick();
    chk("g1_iss_gone", {31'd0, iss_valid}, 32'd0);
    cmp_valid = 1'b1; cmp_addr = S'(2);
    #1;
    chk("g1_wr_en0", {31'd0, ram_wr_en_0}, 32'd1);
    chk("g1_wr_addr0", {12'd0, ram_wr_addr_0}, 32'd2);
    tick();
    cmp_valid = 1'b0;
    chk("g1_not_done", {31'd0, done}, 32'd0);
    tick();
    chk("g1_done", {31'd0, done}, 32'd1);
    tick();

    // operands not ready: stall, then same-cycle bypass from cmp and load
    begin_circuit(1);
    chk("st_cleared", stall_cnt, 32'd0);
    tick();
    desc(1'b1, 2, 3, 4);
    #1;
    chk("st_in_ready0", {31'd0, in_ready}, 32'd0);
    tick(); tick(); tick();
    chk("st_cnt3", stall_cnt, 32'd3);
    cmp_valid = 1'b1; cmp_addr = S'(2); load_en = 1'b1; load_addr = S'(3);
    #1;
    chk("st_bypass_ready", {31'd0, in_ready}, 32'd1);
    tick();
    cmp_valid = 1'b0; load_en = 1'b0; desc(1'b0, 2, 3, 4);
    #1;
    chk("st_iss_a", {12'd0, iss_addr_a}, 32'd2);
    chk("st_iss_o", {12'd0, iss_addr_o}, 32'd4);
    chk("st_cnt_hold", stall_cnt, 32'd3);
    tick();
    cmp_valid = 1'b1; cmp_addr = S'(4);
    tick();
    cmp_valid = 1'b0;
    tick();
    chk("st_done", {31'd0, done}, 32'd1);
    tick();

    // outstanding limit (3) and issue backpressure
    begin_circuit(5);
    tick();
    do_load(0);
    do_load(1);
    iss_ready = 1'b1;
    desc(1'b1, 0, 1, 5);
    #1; chk("ol_c1", {31'd0, in_ready}, 32'd1); tick();
    #1; chk("ol_c2", {31'd0, in_ready}, 32'd1); tick();
    #1; chk("ol_c3", {31'd0, in_ready}, 32'd1); tick();
    #1; chk("ol_c4", {31'd0, in_ready}, 32'd0); tick();
    #1; chk("ol_c5", {31'd0, in_ready}, 32'd0); tick();
    cmp_valid = 1'b1; cmp_addr = S'(5);
    #1; chk("ol_c6", {31'd0, in_ready}, 32'd0); tick();
    cmp_valid = 1'b0; iss_ready = 1'b0; desc(1'b1, 0, 1, 6);
    #1; chk("ol_c7_resume", {31'd0, in_ready}, 32'd1); tick();
    desc(1'b1, 0, 1, 7);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", {31'd0, iss_valid}, 32'd1);
      chk("bp_stable_o", {12'd0, iss_addr_o}, 32'd6);
      chk("bp_no_accept", {31'd0, in_ready}, 32'd0);
      tick();
    end
    iss_ready = 1'b1; cmp_valid = 1'b1; cmp_addr = S'(6);
    #1; chk("bp_c13", {31'd0, in_ready}, 32'd0); tick();
    cmp_valid = 1'b0;
    #1; chk("bp_resume", {31'd0, in_ready}, 32'd1); tick();
    desc(1'b0, 0, 1, 7);
    #1;
    chk("bp_iss_o7", {12'd0, iss_addr_o}, 32'd7);
    chk("bp_stall9", stall_cnt, 32'd9);
    tick();
    cmp_valid = 1'b1; cmp_addr = S'(7);
    tick(); tick(); tick();
    cmp_valid = 1'b0;
    chk("ol_not_done", {31'd0, done}, 32'd0);
    tick();
    chk("ol_done", {31'd0, done}, 32'd1);
    tick();

    // reset mid-circuit with two gates outstanding
    begin_circuit(4);
    tick();
    do_load(0);
    do_load(1);
    iss_ready = 1'b1;
    desc(1'b1, 0, 1, 2);
    tick(); tick();
    desc(1'b0, 0, 1, 2);
    tick();
    chk("mr_busy_pre", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_iss_valid", {31'd0, iss_valid}, 32'd0);
    chk("mr_clr", {31'd0, ram_clr}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    begin_circuit(0);
    chk("mr_new_clr", {31'd0, ram_clr}, 32'd1);
    tick();
    chk("mr_new_done", {31'd0, done}, 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
